// File: rtl/cam_pkg.sv
// Shared constants and types for the camera frame buffer (writer and reader).
package cam_pkg;

    localparam int AW           = 15;
    localparam int FRAME_W      = 176;
    localparam int FRAME_H      = 144;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

    // Bit positions used to reduce RGB565 (byte1 = RRRRRGGG, byte2 = GGGBBBBB) to RGB111.
    localparam int R_BIT = 7;
    localparam int G_BIT = 2;
    localparam int B_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2,
        ST_DONE       = 2'd3
    } cam_state_t;

    // Collapse one RGB565 pixel, given as its two camera bytes, to {R,G,B}.
    function automatic logic [2:0] rgb565_to_111(input logic [7:0] byte1, input logic [7:0] byte2);
        return {byte1[R_BIT], byte1[G_BIT], byte2[B_BIT]};
    endfunction

endpackage

// File: rtl/cam_frame_writer_if.sv
// Camera input and frame-RAM write bundle of the frame writer.
interface cam_frame_writer_if;

    logic                   start;
    logic                   vsync;
    logic                   href;
    logic [7:0]             cam_data;
    logic [cam_pkg::AW-1:0] addr;
    logic [2:0]             data_w;
    logic                   we;
    logic                   busy;
    logic                   frame_ready;
    logic                   frame_short;

    // Writer side: consumes camera signals, produces RAM writes and status.
    modport master (
        input  start, vsync, href, cam_data,
        output addr, data_w, we, busy, frame_ready, frame_short
    );

    // Environment side: camera/controller drives inputs, RAM/reader observes.
    modport slave (
        output start, vsync, href, cam_data,
        input  addr, data_w, we, busy, frame_ready, frame_short
    );

endinterface

// File: rtl/cam_byte_pair.sv
// Pairs camera bytes into pixels: HREF edge detect, byte phase, byte1 latch.
// pix_valid is combinational on the phase-1 byte so the top can register the
// write on the very edge that samples that byte.
module cam_byte_pair
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       href,
    input  logic [7:0] cam_data,
    output logic       pix_valid,
    output logic [2:0] pix_rgb
);

    logic       href_d;
    logic       phase;
    logic [7:0] byte1;
    logic       phase_eff;

    // A new line always starts in phase 0, discarding any odd trailing byte.
    always_comb begin
        phase_eff = phase;
        if (href && !href_d) begin
            phase_eff = 1'b0;
        end else begin
            phase_eff = phase;
        end
        pix_valid = en && href && phase_eff;
        pix_rgb   = rgb565_to_111(byte1, cam_data);
    end

    // Byte phase toggle and first-byte capture; phase held at 0 outside capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            href_d <= 1'b0;
            phase  <= 1'b0;
            byte1  <= 8'd0;
        end else begin
            href_d <= href;
            if (!en) begin
                phase <= 1'b0;
            end else if (href) begin
                phase <= ~phase_eff;
                if (!phase_eff) begin
                    byte1 <= cam_data;
                end
            end
        end
    end

endmodule

// File: rtl/cam_frame_writer.sv
// Captures one camera frame as RGB111 into the 176x144 frame RAM and flags
// completion for the colour-analysis reader.
module cam_frame_writer
    import cam_pkg::*;
(
    input  logic                P,
    input  logic                rst,
    cam_frame_writer_if.master  bus
);

    cam_state_t     state;
    logic           vsync_d;
    logic [AW-1:0]  count;
    logic [AW-1:0]  count_next;
    logic           capture_en;
    logic           vsync_rise;
    logic           vsync_fall;
    logic           wr_now;
    logic           pix_valid;
    logic [2:0]     pix_rgb;

    cam_byte_pair u_byte_pair (
        .clk       (P),
        .rst       (rst),
        .en        (capture_en),
        .href      (bus.href),
        .cam_data  (bus.cam_data),
        .pix_valid (pix_valid),
        .pix_rgb   (pix_rgb)
    );

    // Frame edges, write qualification (no writes past the last address) and next count.
    always_comb begin
        capture_en = (state == ST_CAPTURE);
        vsync_rise = bus.vsync && !vsync_d;
        vsync_fall = !bus.vsync && vsync_d;
        wr_now     = pix_valid && (count < AW'(FRAME_PIXELS));
        if (wr_now) begin
            count_next = count + AW'(1);
        end else begin
            count_next = count;
        end
    end

    // Capture FSM with pixel counter and registered RAM/status outputs.
    always_ff @(posedge P) begin
        if (rst) begin
            state           <= ST_IDLE;
            vsync_d         <= 1'b0;
            count           <= '0;
            bus.addr        <= '0;
            bus.data_w      <= 3'd0;
            bus.we          <= 1'b0;
            bus.busy        <= 1'b0;
            bus.frame_ready <= 1'b0;
            bus.frame_short <= 1'b0;
        end else begin
            vsync_d <= bus.vsync;
            bus.we  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state    <= ST_WAIT_FRAME;
                        bus.busy <= 1'b1;
                        count    <= '0;
                    end
                end
                ST_WAIT_FRAME: begin
                    // Only a fresh frame boundary starts capture, never a partial frame.
                    if (vsync_fall) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (wr_now) begin
                        bus.we     <= 1'b1;
                        bus.addr   <= count;
                        bus.data_w <= pix_rgb;
                    end
                    count <= count_next;
                    if (vsync_rise) begin
                        state           <= ST_DONE;
                        bus.busy        <= 1'b0;
                        bus.frame_ready <= 1'b1;
                        bus.frame_short <= (count_next < AW'(FRAME_PIXELS));
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        state           <= ST_WAIT_FRAME;
                        bus.busy        <= 1'b1;
                        bus.frame_ready <= 1'b0;
                        bus.frame_short <= 1'b0;
                        count           <= '0;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    bus.busy        <= 1'b0;
                    bus.frame_ready <= 1'b0;
                    bus.frame_short <= 1'b0;
                    count           <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Writer side of the camera frame buffer. Captures one frame from the OV7670-style camera port (VSYNC/HREF/8-bit bytes, RGB565, two bytes per pixel), reduces each pixel to 3-bit RGB111, and writes it sequentially into the 176×144 frame RAM at addresses 0..25343. On completion it raises `frame_ready`, which drives the `read` input of the colour-analysis reader that scans the same RAM.

## Interface
- `AW`, 15, frame RAM address width
- `FRAME_PIXELS`, 25344, pixels per frame (176×144); last address `FRAME_PIXELS-1`
- `P`  in  1  camera pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  capture request; sampled in IDLE and DONE
- `vsync`  in  1  camera VSYNC; high = vertical blanking
- `href`  in  1  camera HREF; high = valid byte on `cam_data`
- `cam_data`  in  8  camera byte
- `addr`  out  AW  RAM write address
- `data_w`  out  3  RAM write data {R,G,B}
- `we`  out  1  RAM write enable, one-cycle pulse per pixel
- `busy`  out  1  high in WAIT_FRAME and CAPTURE
- `frame_ready`  out  1  high in DONE; level, not pulse
- `frame_short`  out  1  valid with `frame_ready`; fewer than FRAME_PIXELS pixels written

## Operation
- States: IDLE, WAIT_FRAME, CAPTURE, DONE.
- IDLE: `start`=1 → WAIT_FRAME; pixel count cleared.
- WAIT_FRAME: wait for VSYNC falling edge (`vsync_d`=1, `vsync`=0) → CAPTURE. Bytes ignored here, so a partial frame is never captured.
- CAPTURE: with `href`=1, byte phase alternates. Phase 0 latches byte1, with R=byte1[7] and G=byte1[2]. Phase 1 takes B=byte2[4] and issues a write.
- The phase resets to 0 on every HREF rising edge. An odd trailing byte at the end of a line is discarded.
- Count is AW bits. Writes are issued only while count < FRAME_PIXELS. Bytes after the last pixel are discarded, with no wrap to address 0.
- VSYNC rising edge in CAPTURE → DONE. `frame_short` = (count < FRAME_PIXELS).
- DONE: `frame_ready`=1 and buffer contents are stable. `start`=1 → WAIT_FRAME, clearing `frame_ready`, `frame_short` and the count in the same edge.
- `start` in WAIT_FRAME or CAPTURE is ignored.
- Reset values: state IDLE; `addr`=0, `data_w`=0, `we`=0, `busy`=0, `frame_ready`=0, `frame_short`=0; phase 0; count 0; `vsync_d`=0.
- Reset mid-capture aborts immediately. `we` is low from the next edge. RAM contents are left as is.

## Timing
- All outputs are registered on rising `P`.
- The Phase-1 byte is sampled at edge N. At edge N, `we`=1, `addr`=count and `data_w` are registered, and count increments. `we` drops at N+1 unless the next pixel completes.
- The fastest write rate is one write every 2 cycles, so `we` is never high on two consecutive cycles.
- Edge detection uses a 1-cycle registered `vsync_d`.
- The transition into CAPTURE happens at the edge that observes the falling VSYNC. A byte with `href`=1 at that same edge is ignored.
- A VSYNC rising edge in the same cycle as a phase-1 byte: the write is issued and the state goes to DONE at that edge.
- `frame_ready` rises 1 cycle after the VSYNC rising edge is observed.

## Structure
- Shared package `cam_pkg` holds `FRAME_PIXELS`, `FRAME_W`=176, `FRAME_H`=144, the state enum and the RGB565→RGB111 bit positions (7, 2, 4). The reader uses the same constants.
- One sub-module, `cam_byte_pair`, handles HREF edge detection, the byte phase toggle and byte1 latching. It outputs `pix_valid` (1 cycle) and `pix_rgb[2:0]`. FSM, counter and outputs stay in the top level.

## Test plan
- Full frame: 144 lines of 352 bytes, all pixels 0xF8,0x00 (red) → 25344 `we` pulses with `data_w`=3'b100 at addresses 0..25343. Then `frame_ready`=1 and `frame_short`=0.
- Frame starting mid-capture: assert `start` with `vsync` low and HREF active → no `we` until VSYNC has gone high and then low. The first write goes to address 0.
- Short frame: 10 lines then a VSYNC rising edge → 1760 writes, last at address 1759. Then `frame_ready`=1 and `frame_short`=1.
- Odd byte plus long frame: a line of 351 bytes gives 175 writes and the next line starts in phase 0. In a separate run, 145 lines cause writes to stop after address 25343, with no write to address 0.
- Pixel 0x04,0x10 → `data_w`=3'b011. Pixel 0x00,0x00 → `data_w`=3'b000.
- Reset at pixel 1000 → `we`=0 the next cycle and all outputs at reset values. A new `start` captures a fresh frame from address 0.
